regfile_bypass: RTL
===================

# regfile_bypass

Parametrised general-purpose register file for the integer pipeline: one write port with write-to-read bypass, NUM_RD combinational read ports, a per-register pending-write scoreboard for hazard detection, and a reset-time clear sweep that drives every entry to zero. It sits between decode (read and scoreboard query), issue (scoreboard set) and writeback (write and scoreboard clear).

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register index width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports (1..4).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once the clear sweep has completed.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port i index has a pending write.
- we  in  1  write enable.
- wa  in  ADDR_W  write index.
- wd  in  DATA_W  write data.
- iss_valid  in  1  an instruction is issuing with a destination register.
- iss_rd  in  ADDR_W  destination index of the issuing instruction.

## Operation
- State machine with two states.
  - CLEAR: entered on any cycle with rst=1 and held while rst=1. After rst falls, counter clr_idx steps from 0 to DEPTH-1, writing 0 to rf[clr_idx] once per cycle. Move to RUN after writing DEPTH-1.
  - RUN: normal operation.
- rst asserted while in RUN or mid-sweep: return to CLEAR and restart the sweep from clr_idx=0.
- Behaviour in CLEAR:
  - we and iss_valid are ignored.
  - rd_data reads 0 and rd_busy reads 0 on all ports.
  - init_done=0.
- Writes in RUN: if we=1 and wa!=0, rf[wa] <= wd at the rising edge. A write to index 0 is discarded.
- Reads in RUN are combinational, per port i:
  - rd_addr_i==0: return 0.
  - Else if we=1 and wa==rd_addr_i: return wd (bypass).
  - Else: return rf[rd_addr_i].
- Scoreboard: busy[DEPTH-1:1], registered; busy[0] is constant 0. Updates in RUN:
  - iss_valid=1 and iss_rd!=0: busy[iss_rd] <= 1.
  - we=1 and wa!=0: busy[wa] <= 0.
  - Same index set and cleared in the same cycle: set wins, because the new producer supersedes the retiring one.
- rd_busy_i = busy[rd_addr_i] & ~(we & wa==rd_addr_i). The bypassed value is valid, so the port is not reported busy.
- The scoreboard is cleared to all-zero on the first rst cycle, not by the sweep.

## Timing
- Read latency 0 cycles (combinational). Write visible through the bypass in the same cycle, and from the array from the next cycle.
- Scoreboard set and clear visible on rd_busy the cycle after the issue or writeback edge.
- Reset values:
  - init_done=0, busy=0, clr_idx=0.
  - rd_data=0 and rd_busy=0 while in CLEAR.
- Sweep length: DEPTH cycles after rst deasserts.
  - init_done rises on the edge that writes entry DEPTH-1. It is high in the following cycle (cycle DEPTH after rst falls).
  - Entry 0 is written but is never read back.
- clr_idx wraps only via the state transition and never overruns DEPTH-1.
- No stall output. Upstream must hold issue until init_done=1.

## Structure
- DATA_W, ADDR_W and the default NUM_RD come from the existing `DATA_WIDTH and `RD_WIDTH defines in include.v.
- Add `RF_DEPTH to include.v.
- Add state encodings `RF_ST_CLEAR=1'b0 and `RF_ST_RUN=1'b1 to include.v.
- One sub-module, rf_scoreboard: the busy vector, set/clear priority and per-port busy lookup. Instantiated once.
- Read ports are generated with a generate loop over NUM_RD.

## Test plan
- Reset sweep: pulse rst for 3 cycles, then deassert -> init_done=0 for exactly 32 cycles, then 1. Every index then reads 0.
- Write/read: write wd=0xDEADBEEF to wa=5, then read on port 1 the next cycle -> 0xDEADBEEF. Write 0x1234 to wa=0 -> reads of index 0 return 0.
- Bypass: we=1, wa=7, wd=0xA5A5A5A5 with rd_addr port 0 = 7 in the same cycle -> rd_data port 0 = 0xA5A5A5A5 and rd_busy port 0 = 0 in that cycle.
- Scoreboard:
  - iss_valid with iss_rd=9 -> rd_busy=1 for index 9 from the next cycle.
  - Then issue iss_rd=9 and write wa=9 in the same cycle -> busy remains 1.
  - Then write wa=9 alone -> busy=0 in the cycle after.
- Mid-sweep reset: assert rst when clr_idx=12 -> sweep restarts at 0. init_done rises 32 cycles after the second rst falls.
- Mid-run reset with busy[3]=1 and rf[3]=0x55 -> busy=0 after the reset edge, and rf[3] reads 0 after init_done.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// Shared definitions for the register file with write bypass.
// Contents:
//   RF_DATA_W / RF_ADDR_W / RF_NUM_RD - default register width, index width and read-port count
//   RF_DEPTH                          - number of entries implied by the default index width
//   rf_state_e                        - two-state controller encoding (clear sweep / normal run)
package regfile_bypass_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NUM_RD = 2;
  localparam int unsigned RF_DEPTH  = 1 << RF_ADDR_W;

  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_bypass_scoreboard.sv
// rf_scoreboard: per-register pending-write tracking.
// A bit is set when an instruction issues with that destination and cleared
// when writeback writes it. Entry 0 never becomes busy.
// Ports:
//   clk, rst       - clock, synchronous active-high reset (clears every bit)
//   en_i           - high only in normal operation; gates updates and lookups
//   iss_valid_i    - issue with destination iss_rd_i
//   we_i, wa_i     - writeback enable and index
//   rd_addr_i      - packed read indices, NUM_RD x ADDR_W
//   rd_busy_o      - per-port busy flag (masked when the same index is being written)
module rf_scoreboard #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_rd_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        wa_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (en_i) begin
      for (int i = 1; i < DEPTH; i++) begin
        // Clear first, then set: a new producer supersedes the retiring one.
        if (we_i && (wa_i == ADDR_W'(i))) busy_d[i] = 1'b0;
        if (iss_valid_i && (iss_rd_i == ADDR_W'(i))) busy_d[i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A port being written this cycle sees the bypassed value, so it is not busy.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_lookup
    logic [ADDR_W-1:0] addr;
    assign addr         = rd_addr_i[g*ADDR_W +: ADDR_W];
    assign rd_busy_o[g] = en_i && busy_q[addr] && !(we_i && (wa_i == addr));
  end

endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: general-purpose register file for the integer pipeline.
// One write port with same-cycle write-to-read bypass, NUM_RD combinational
// read ports, a pending-write scoreboard, and a clear sweep after reset that
// writes zero to every entry, one per cycle.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   init_done           - high once the clear sweep has finished (normal operation)
//   rd_addr / rd_data   - packed read indices / data, port i at slice i
//   rd_busy             - port i index has a pending write
//   we, wa, wd          - writeback port (index 0 is discarded)
//   iss_valid, iss_rd   - issue of an instruction with a destination register
//   dbg_state           - controller state, for observation only
// Interfaces here are plain strobes: there is no valid/ready back-pressure;
// upstream holds issue until init_done is high.
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = RF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_rd,
  output rf_state_e                dbg_state
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] rf_q [DEPTH];

  logic sweep_we;
  logic run;
  logic wr_en;

  // A cycle with rst high behaves as CLEAR even if the register still says RUN.
  assign sweep_we  = (state_q == RF_ST_CLEAR) && !rst;
  assign run       = (state_q == RF_ST_RUN) && !rst;
  assign wr_en     = run && we && (wa != '0);
  assign init_done = run;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      RF_ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = RF_ST_RUN;
          clr_idx_d = '0;
        end
      end
      RF_ST_RUN: begin
        state_d = RF_ST_RUN;
      end
      default: begin
        state_d   = RF_ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Storage has no reset of its own; the sweep provides the zero state.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      rf_q[clr_idx_q] <= '0;
    end else if (wr_en) begin
      rf_q[wa] <= wd;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[g*ADDR_W +: ADDR_W];
    assign rd_data[g*DATA_W +: DATA_W] =
      (!run || (addr == '0)) ? '0 :
      (we && (wa == addr))   ? wd :
                               rf_q[addr];
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .en_i        (run),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .we_i        (we),
    .wa_i        (wa),
    .rd_addr_i   (rd_addr),
    .rd_busy_o   (rd_busy)
  );

endmodule
